// File: rtl/bp_cfg_node.sv
// Config-link endpoint for one tile: decodes config commands, keeps the
// tile control registers locally, and forwards register-file, CSR and
// CCE-ucode accesses over a single stalling remote request/response port.
module bp_cfg_node #(
  parameter int unsigned addr_width_p       = 20,
  parameter int unsigned data_width_p       = 64,
  parameter int unsigned vaddr_width_p      = 39,
  parameter int unsigned core_id_width_p    = 8,
  parameter int unsigned did_width_p        = 8,
  parameter int unsigned cord_width_p       = 8,
  parameter int unsigned cache_mode_width_p = 2,
  parameter int unsigned cce_mode_width_p   = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic                          cfg_v_i,
  input  logic                          cfg_w_i,
  input  logic [addr_width_p-1:0]       cfg_addr_i,
  input  logic [data_width_p-1:0]       cfg_data_i,
  output logic                          cfg_ready_o,

  output logic                          cfg_resp_v_o,
  output logic [data_width_p-1:0]       cfg_resp_data_o,
  input  logic                          cfg_resp_yumi_i,

  output logic                          remote_v_o,
  output logic                          remote_w_o,
  output logic [15:0]                   remote_addr_o,
  output logic [data_width_p-1:0]       remote_data_o,
  input  logic                          remote_ready_i,
  input  logic                          remote_resp_v_i,
  input  logic [data_width_p-1:0]       remote_resp_data_i,

  output logic                          reset_o,
  output logic                          freeze_o,
  output logic                          debug_o,
  output logic [core_id_width_p-1:0]    core_id_o,
  output logic [did_width_p-1:0]        did_o,
  output logic [cord_width_p-1:0]       cord_o,
  output logic [cache_mode_width_p-1:0] icache_mode_o,
  output logic [cache_mode_width_p-1:0] dcache_mode_o,
  output logic [cce_mode_width_p-1:0]   cce_mode_o,
  output logic [vaddr_width_p-1:0]      npc_o,
  output logic                          npc_w_v_o
);

  typedef enum logic [1:0] {
    READY = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e state_reg, state_next;

  // Tile control registers
  logic                          reset_reg, freeze_reg, debug_reg;
  logic [core_id_width_p-1:0]    core_id_reg;
  logic [did_width_p-1:0]        did_reg;
  logic [cord_width_p-1:0]       cord_reg;
  logic [cache_mode_width_p-1:0] icache_mode_reg, dcache_mode_reg;
  logic [cce_mode_width_p-1:0]   cce_mode_reg;
  logic [vaddr_width_p-1:0]      npc_reg;
  logic                          npc_w_v_reg;

  // Latched remote request and the pending response word
  logic                          rem_w_reg;
  logic [15:0]                   rem_addr_reg;
  logic [data_width_p-1:0]       rem_data_reg;
  logic [data_width_p-1:0]       resp_data_reg;

  // Decode signals
  logic [15:0]             addr_lo;
  logic                    addr_hi_zero;
  logic                    is_remote;
  logic                    accept;
  logic [data_width_p-1:0] local_rdata;

  assign addr_lo = cfg_addr_i[15:0];

  // Any set bit above the decoded 16 makes the access unmapped.
  generate
    if (addr_width_p > 16) begin : g_addr_hi
      assign addr_hi_zero = ~|cfg_addr_i[addr_width_p-1:16];
    end else begin : g_addr_no_hi
      assign addr_hi_zero = 1'b1;
    end
  endgenerate

  assign accept = cfg_v_i & (state_reg == READY);

  // Remote windows: irf x0-x31, CSR page, CCE ucode page
  always_comb begin
    is_remote = 1'b0;
    if (addr_hi_zero) begin
      is_remote = ((addr_lo >= 16'h0050) && (addr_lo <= 16'h006F))
               || (addr_lo[15:12] == 4'h6)
               || (addr_lo[15:12] == 4'h8);
    end
  end

  // Local readback mux; unmapped addresses read as zero
  always_comb begin
    local_rdata = '0;
    if (addr_hi_zero) begin
      case (addr_lo)
        16'h0001: local_rdata = data_width_p'(reset_reg);
        16'h0002: local_rdata = data_width_p'(freeze_reg);
        16'h0003: local_rdata = data_width_p'(debug_reg);
        16'h0004: local_rdata = data_width_p'(debug_reg);
        16'h0005: local_rdata = data_width_p'(core_id_reg);
        16'h0006: local_rdata = data_width_p'(did_reg);
        16'h0007: local_rdata = data_width_p'(cord_reg);
        16'h0022: local_rdata = data_width_p'(icache_mode_reg);
        16'h0040: local_rdata = data_width_p'(npc_reg);
        16'h0043: local_rdata = data_width_p'(dcache_mode_reg);
        16'h0081: local_rdata = data_width_p'(cce_mode_reg);
        default:  local_rdata = '0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_reg <= READY;
    else         state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      READY: if (cfg_v_i)          state_next = is_remote ? REQ : RESP;
      REQ:   if (remote_ready_i)   state_next = WAIT;
      WAIT:  if (remote_resp_v_i)  state_next = RESP;
      RESP:  if (cfg_resp_yumi_i)  state_next = READY;
      default:                     state_next = READY;
    endcase
  end

  // FSM outputs
  always_comb begin
    cfg_ready_o  = (state_reg == READY);
    remote_v_o   = (state_reg == REQ);
    cfg_resp_v_o = (state_reg == RESP);
  end

  // Local register writes land in the acceptance cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      reset_reg       <= 1'b1;
      freeze_reg      <= 1'b1;
      debug_reg       <= 1'b0;
      core_id_reg     <= '0;
      did_reg         <= '0;
      cord_reg        <= '0;
      icache_mode_reg <= '0;
      dcache_mode_reg <= '0;
      cce_mode_reg    <= '0;
      npc_reg         <= '0;
      npc_w_v_reg     <= 1'b0;
    end else begin
      npc_w_v_reg <= accept & cfg_w_i & addr_hi_zero & (addr_lo == 16'h0040);
      if (accept & cfg_w_i & addr_hi_zero) begin
        case (addr_lo)
          16'h0001: reset_reg       <= cfg_data_i[0];
          16'h0002: freeze_reg      <= cfg_data_i[0];
          16'h0003: debug_reg       <= 1'b1;
          16'h0004: debug_reg       <= 1'b0;
          16'h0005: core_id_reg     <= cfg_data_i[core_id_width_p-1:0];
          16'h0006: did_reg         <= cfg_data_i[did_width_p-1:0];
          16'h0007: cord_reg        <= cfg_data_i[cord_width_p-1:0];
          16'h0022: icache_mode_reg <= cfg_data_i[cache_mode_width_p-1:0];
          16'h0040: npc_reg         <= cfg_data_i[vaddr_width_p-1:0];
          16'h0043: dcache_mode_reg <= cfg_data_i[cache_mode_width_p-1:0];
          16'h0081: cce_mode_reg    <= cfg_data_i[cce_mode_width_p-1:0];
          default: ;
        endcase
      end
    end
  end

  // Remote request latch and response word capture
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rem_w_reg     <= 1'b0;
      rem_addr_reg  <= '0;
      rem_data_reg  <= '0;
      resp_data_reg <= '0;
    end else begin
      if (accept & is_remote) begin
        rem_w_reg    <= cfg_w_i;
        rem_addr_reg <= addr_lo;
        rem_data_reg <= cfg_data_i;
      end
      if (accept & ~is_remote) begin
        resp_data_reg <= cfg_w_i ? '0 : local_rdata;
      end else if ((state_reg == WAIT) & remote_resp_v_i) begin
        resp_data_reg <= rem_w_reg ? '0 : remote_resp_data_i;
      end
    end
  end

  assign cfg_resp_data_o = resp_data_reg;
  assign remote_w_o      = rem_w_reg;
  assign remote_addr_o   = rem_addr_reg;
  assign remote_data_o   = rem_data_reg;

  assign reset_o       = reset_reg;
  assign freeze_o      = freeze_reg;
  assign debug_o       = debug_reg;
  assign core_id_o     = core_id_reg;
  assign did_o         = did_reg;
  assign cord_o        = cord_reg;
  assign icache_mode_o = icache_mode_reg;
  assign dcache_mode_o = dcache_mode_reg;
  assign cce_mode_o    = cce_mode_reg;
  assign npc_o         = npc_reg;
  assign npc_w_v_o     = npc_w_v_reg;

endmodule

// File: tb/tb_bp_cfg_node.sv
// Directed bench for bp_cfg_node: local map, remote stall path,
// unmapped accesses and reset abort of a remote transaction.
module tb_bp_cfg_node;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        cfg_v_i, cfg_w_i;
  logic [19:0] cfg_addr_i;
  logic [63:0] cfg_data_i;
  logic        cfg_ready_o;
  logic        cfg_resp_v_o;
  logic [63:0] cfg_resp_data_o;
  logic        cfg_resp_yumi_i;
  logic        remote_v_o, remote_w_o;
  logic [15:0] remote_addr_o;
  logic [63:0] remote_data_o;
  logic        remote_ready_i, remote_resp_v_i;
  logic [63:0] remote_resp_data_i;
  logic        reset_o, freeze_o, debug_o, npc_w_v_o;
  logic [7:0]  core_id_o, did_o, cord_o;
  logic [1:0]  icache_mode_o, dcache_mode_o;
  logic [0:0]  cce_mode_o;
  logic [38:0] npc_o;

  int checks = 0;
  int errors = 0;
  int npc_pulses = 0;
  int remote_v_seen = 0;
  logic [63:0] rd;

  bp_cfg_node dut (
    .clk_i(clk), .reset_i(reset_i),
    .cfg_v_i(cfg_v_i), .cfg_w_i(cfg_w_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .cfg_ready_o(cfg_ready_o),
    .cfg_resp_v_o(cfg_resp_v_o), .cfg_resp_data_o(cfg_resp_data_o),
    .cfg_resp_yumi_i(cfg_resp_yumi_i),
    .remote_v_o(remote_v_o), .remote_w_o(remote_w_o),
    .remote_addr_o(remote_addr_o), .remote_data_o(remote_data_o),
    .remote_ready_i(remote_ready_i), .remote_resp_v_i(remote_resp_v_i),
    .remote_resp_data_i(remote_resp_data_i),
    .reset_o(reset_o), .freeze_o(freeze_o), .debug_o(debug_o),
    .core_id_o(core_id_o), .did_o(did_o), .cord_o(cord_o),
    .icache_mode_o(icache_mode_o), .dcache_mode_o(dcache_mode_o),
    .cce_mode_o(cce_mode_o), .npc_o(npc_o), .npc_w_v_o(npc_w_v_o)
  );

  always #5 clk = ~clk;

  // Pulse/activity monitors sampled on the falling edge
  always @(negedge clk) begin
    if (npc_w_v_o)  npc_pulses++;
    if (remote_v_o) remote_v_seen++;
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full cfg transaction with immediate yumi; returns response data
  task automatic cfg_txn(input logic w, input logic [19:0] addr, input logic [63:0] data,
                         output logic [63:0] rdata);
    int cnt;
    cfg_v_i = 1'b1; cfg_w_i = w; cfg_addr_i = addr; cfg_data_i = data;
    cnt = 0;
    while (!cfg_ready_o && cnt < 50) begin tick(); cnt++; end
    if (cnt >= 50) check_value("ready_timeout", 64'(cfg_ready_o), 64'd1);
    tick();
    cfg_v_i = 1'b0;
    cnt = 0;
    while (!cfg_resp_v_o && cnt < 50) begin tick(); cnt++; end
    if (cnt >= 50) check_value("resp_timeout", 64'(cfg_resp_v_o), 64'd1);
    rdata = cfg_resp_data_o;
    cfg_resp_yumi_i = 1'b1;
    tick();
    cfg_resp_yumi_i = 1'b0;
    $display("txn %s addr=0x%05h wdata=0x%0h resp=0x%0h", w ? "WR" : "RD", addr, data, rdata);
  endtask

  initial begin
    reset_i = 1'b1; cfg_v_i = 1'b0; cfg_w_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    cfg_resp_yumi_i = 1'b0; remote_ready_i = 1'b0; remote_resp_v_i = 1'b0;
    remote_resp_data_i = '0;
    repeat (3) tick();
    reset_i = 1'b0;

    // Reset state
    check_value("rst_reset_o", 64'(reset_o), 64'd1);
    check_value("rst_freeze_o", 64'(freeze_o), 64'd1);
    check_value("rst_debug_o", 64'(debug_o), 64'd0);
    check_value("rst_ready", 64'(cfg_ready_o), 64'd1);
    check_value("rst_resp_v", 64'(cfg_resp_v_o), 64'd0);
    check_value("rst_remote_v", 64'(remote_v_o), 64'd0);
    check_value("rst_npc_w_v", 64'(npc_w_v_o), 64'd0);

    cfg_txn(1'b0, 20'h00001, 64'd0, rd); check_value("rd_reset", rd, 64'd1);
    cfg_txn(1'b0, 20'h00002, 64'd0, rd); check_value("rd_freeze", rd, 64'd1);
    cfg_txn(1'b0, 20'h00005, 64'd0, rd); check_value("rd_core_id", rd, 64'd0);

    // NPC write: value visible, single pulse, readback
    npc_pulses = 0;
    cfg_txn(1'b1, 20'h00040, 64'h80000124, rd);
    check_value("npc_wr_ack", rd, 64'd0);
    check_value("npc_o", 64'(npc_o), 64'h80000124);
    tick();
    check_value("npc_pulses", 64'(npc_pulses), 64'd1);
    cfg_txn(1'b0, 20'h00040, 64'd0, rd); check_value("rd_npc", rd, 64'h80000124);
    check_value("npc_pulses_rd", 64'(npc_pulses), 64'd1);

    // Debug enter/exit
    cfg_txn(1'b1, 20'h00003, 64'd0, rd);
    check_value("debug_set", 64'(debug_o), 64'd1);
    cfg_txn(1'b0, 20'h00003, 64'd0, rd); check_value("rd_debug3", rd, 64'd1);
    cfg_txn(1'b0, 20'h00004, 64'd0, rd); check_value("rd_debug4", rd, 64'd1);
    cfg_txn(1'b1, 20'h00004, 64'd0, rd);
    check_value("debug_clr", 64'(debug_o), 64'd0);

    // Width truncation on narrow registers
    cfg_txn(1'b1, 20'h00005, 64'h1A5, rd);
    check_value("core_id_o", 64'(core_id_o), 64'hA5);
    cfg_txn(1'b0, 20'h00005, 64'd0, rd); check_value("rd_core_id2", rd, 64'hA5);
    cfg_txn(1'b1, 20'h00022, 64'hF, rd);
    check_value("icache_mode_o", 64'(icache_mode_o), 64'd3);
    cfg_txn(1'b0, 20'h00022, 64'd0, rd); check_value("rd_icache", rd, 64'd3);

    // Remote read of irf x5 with stalled request and delayed response
    cfg_v_i = 1'b1; cfg_w_i = 1'b0; cfg_addr_i = 20'h00055; cfg_data_i = '0;
    check_value("rem_ready_pre", 64'(cfg_ready_o), 64'd1);
    tick();
    cfg_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_value("rem_v_stall", 64'(remote_v_o), 64'd1);
      check_value("rem_addr", 64'(remote_addr_o), 64'h0055);
      check_value("rem_w", 64'(remote_w_o), 64'd0);
      check_value("rem_ready_req", 64'(cfg_ready_o), 64'd0);
      tick();
    end
    remote_ready_i = 1'b1;
    check_value("rem_v_hs", 64'(remote_v_o), 64'd1);
    check_value("rem_addr_hs", 64'(remote_addr_o), 64'h0055);
    tick();
    remote_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_value("rem_v_wait", 64'(remote_v_o), 64'd0);
      check_value("rem_ready_wait", 64'(cfg_ready_o), 64'd0);
      check_value("rem_resp_v_wait", 64'(cfg_resp_v_o), 64'd0);
      tick();
    end
    remote_resp_v_i = 1'b1; remote_resp_data_i = 64'hDEAD;
    tick();
    remote_resp_v_i = 1'b0; remote_resp_data_i = '0;
    check_value("rem_resp_v", 64'(cfg_resp_v_o), 64'd1);
    check_value("rem_resp_data", cfg_resp_data_o, 64'hDEAD);
    check_value("rem_ready_resp", 64'(cfg_ready_o), 64'd0);
    tick();
    check_value("rem_resp_hold", cfg_resp_data_o, 64'hDEAD);
    cfg_resp_yumi_i = 1'b1;
    tick();
    cfg_resp_yumi_i = 1'b0;
    check_value("rem_ready_post", 64'(cfg_ready_o), 64'd1);
    check_value("rem_resp_v_post", 64'(cfg_resp_v_o), 64'd0);
    $display("txn RD addr=0x00055 remote resp=0xdead");

    // Unmapped accesses, including a set bit above the decoded range
    remote_v_seen = 0;
    cfg_txn(1'b1, 20'h00100, 64'h55, rd); check_value("unm_wr_ack", rd, 64'd0);
    cfg_txn(1'b0, 20'h00100, 64'd0, rd);  check_value("unm_rd", rd, 64'd0);
    cfg_txn(1'b0, 20'h10001, 64'd0, rd);  check_value("unm_hi_rd", rd, 64'd0);
    cfg_txn(1'b1, 20'h10005, 64'h33, rd);
    check_value("unm_remote_v", 64'(remote_v_seen), 64'd0);
    check_value("unm_core_id", 64'(core_id_o), 64'hA5);
    check_value("unm_npc", 64'(npc_o), 64'h80000124);
    check_value("unm_reset_o", 64'(reset_o), 64'd1);

    // Reset during WAIT of a ucode write
    cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = 20'h08000; cfg_data_i = 64'h1234;
    tick();
    cfg_v_i = 1'b0;
    check_value("uc_remote_v", 64'(remote_v_o), 64'd1);
    check_value("uc_remote_w", 64'(remote_w_o), 64'd1);
    check_value("uc_remote_addr", 64'(remote_addr_o), 64'h8000);
    check_value("uc_remote_data", remote_data_o, 64'h1234);
    remote_ready_i = 1'b1;
    tick();
    remote_ready_i = 1'b0;
    check_value("uc_wait_remote_v", 64'(remote_v_o), 64'd0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_value("uc_rst_ready", 64'(cfg_ready_o), 64'd1);
    check_value("uc_rst_resp_v", 64'(cfg_resp_v_o), 64'd0);
    check_value("uc_rst_core_id", 64'(core_id_o), 64'd0);
    remote_resp_v_i = 1'b1; remote_resp_data_i = 64'hBEEF;
    tick();
    remote_resp_v_i = 1'b0; remote_resp_data_i = '0;
    check_value("uc_late_resp_v", 64'(cfg_resp_v_o), 64'd0);
    check_value("uc_late_ready", 64'(cfg_ready_o), 64'd1);
    tick();
    check_value("uc_late_resp_v2", 64'(cfg_resp_v_o), 64'd0);
    $display("txn WR addr=0x08000 aborted by reset");
    cfg_txn(1'b0, 20'h00002, 64'd0, rd); check_value("post_rst_freeze", rd, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
